// File: rtl/sevenseg_scan_if.sv
// Bus bundle between a display client and the seven-segment scan controller.
interface sevenseg_scan_if #(
    parameter int unsigned DIGITS = 8
);
    logic                  enable;
    logic                  load;
    logic [4*DIGITS-1:0]   value;
    logic [DIGITS-1:0]     dp_in;
    logic                  lz_blank;
    logic [3:0]            digit_data;
    logic [DIGITS-1:0]     an_n;
    logic                  dp_n;
    logic                  frame_tick;

    modport master (
        output enable, load, value, dp_in, lz_blank,
        input  digit_data, an_n, dp_n, frame_tick
    );

    modport slave (
        input  enable, load, value, dp_in, lz_blank,
        output digit_data, an_n, dp_n, frame_tick
    );
endinterface

// File: rtl/sevenseg_scan.sv
// Time-multiplexed scan controller for a common-anode multi-digit
// seven-segment display. Updates are latched into a shadow register and
// promoted to the display register only at frame boundaries.
module sevenseg_scan #(
    parameter int unsigned DIGITS       = 8,
    parameter int unsigned REFRESH_DIV  = 100000,
    parameter int unsigned BLANK_CYCLES = 1000
) (
    input  logic           clk,
    input  logic           rst_n,
    sevenseg_scan_if.slave bus
);
    localparam int unsigned CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int unsigned IW = $clog2(DIGITS);
    localparam logic [CW-1:0] SHOW_LAST = CW'(REFRESH_DIV - BLANK_CYCLES - 1);
    localparam logic [CW-1:0] SLOT_LAST = CW'(REFRESH_DIV - 1);
    localparam logic [IW-1:0] IDX_LAST  = IW'(DIGITS - 1);

    typedef enum logic [1:0] {IDLE, SHOW, BLANK} state_t;

    state_t              state, state_d;
    logic [CW-1:0]       cnt, cnt_d;
    logic [IW-1:0]       idx, idx_d;
    logic [4*DIGITS-1:0] sh_val, sh_val_d, disp_val, disp_val_d;
    logic [DIGITS-1:0]   sh_dp, sh_dp_d, disp_dp, disp_dp_d;
    logic                boundary;

    logic [3:0]          nib [DIGITS];
    logic [DIGITS-1:0]   lz_mask;
    logic                zero_run;

    logic [3:0]          data_q, data_d;
    logic [DIGITS-1:0]   an_q, an_d;
    logic                dp_q, dp_d;
    logic                tick_q, tick_d;

    // Next-state logic for scan position, shadow and display registers.
    always_comb begin
        boundary   = (state == BLANK) && (cnt == SLOT_LAST) && (idx == IDX_LAST);
        sh_val_d   = bus.load ? bus.value : sh_val;
        sh_dp_d    = bus.load ? bus.dp_in : sh_dp;
        // Using the post-load shadow gives the same-cycle bypass for a
        // load that lands exactly on the frame boundary.
        disp_val_d = disp_val;
        disp_dp_d  = disp_dp;
        if ((state == IDLE) || boundary) begin
            disp_val_d = sh_val_d;
            disp_dp_d  = sh_dp_d;
        end

        state_d = state;
        cnt_d   = cnt;
        idx_d   = idx;
        if (!bus.enable) begin
            state_d = IDLE;
            cnt_d   = '0;
            idx_d   = '0;
        end else begin
            unique case (state)
                IDLE: begin
                    state_d = SHOW;
                    cnt_d   = '0;
                    idx_d   = '0;
                end
                SHOW: begin
                    cnt_d = cnt + 1'b1;
                    if (cnt == SHOW_LAST) state_d = BLANK;
                end
                BLANK: begin
                    if (cnt == SLOT_LAST) begin
                        cnt_d   = '0;
                        idx_d   = (idx == IDX_LAST) ? '0 : idx + 1'b1;
                        state_d = SHOW;
                    end else begin
                        cnt_d = cnt + 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // Output values derived from the upcoming state so registered outputs line up with it.
    always_comb begin
        for (int unsigned k = 0; k < DIGITS; k++) begin
            nib[k] = disp_val_d[4*k +: 4];
        end
        zero_run = 1'b1;
        lz_mask  = '0;
        for (int unsigned k = 0; k < DIGITS; k++) begin
            zero_run = zero_run && (nib[DIGITS-1-k] == 4'h0);
            lz_mask[DIGITS-1-k] = zero_run && bus.lz_blank && (k != DIGITS - 1);
        end

        data_d = data_q;
        an_d   = '1;
        dp_d   = dp_q;
        tick_d = 1'b0;
        unique case (state_d)
            SHOW: begin
                data_d = nib[idx_d];
                if (lz_mask[idx_d]) begin
                    dp_d = 1'b1;
                end else begin
                    an_d[idx_d] = 1'b0;
                    dp_d        = ~disp_dp_d[idx_d];
                end
            end
            BLANK: begin
                tick_d = (cnt_d == SLOT_LAST) && (idx_d == IDX_LAST);
            end
            default: begin
                dp_d = 1'b1;
            end
        endcase
    end

    // State, counters, data registers and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            cnt      <= '0;
            idx      <= '0;
            sh_val   <= '0;
            sh_dp    <= '0;
            disp_val <= '0;
            disp_dp  <= '0;
            data_q   <= '0;
            an_q     <= '1;
            dp_q     <= 1'b1;
            tick_q   <= 1'b0;
        end else begin
            state    <= state_d;
            cnt      <= cnt_d;
            idx      <= idx_d;
            sh_val   <= sh_val_d;
            sh_dp    <= sh_dp_d;
            disp_val <= disp_val_d;
            disp_dp  <= disp_dp_d;
            data_q   <= data_d;
            an_q     <= an_d;
            dp_q     <= dp_d;
            tick_q   <= tick_d;
        end
    end

    assign bus.digit_data = data_q;
    assign bus.an_n       = an_q;
    assign bus.dp_n       = dp_q;
    assign bus.frame_tick = tick_q;
endmodule

// File: doc/sevenseg_scan.md
# sevenseg_scan

Time-multiplexed scan controller for a common-anode multi-digit seven-segment display. It captures a packed hex word plus decimal points and steps through the digits at a fixed refresh rate. For each digit it drives the 4-bit nibble into the downstream `sevenseg_hex` decoder (`digit_data` → `data`) and asserts one active-low anode. A blanking gap between digits suppresses ghosting, and display updates are applied only at frame boundaries to avoid tearing.

## Interface
- `DIGITS`, 8: number of digits scanned (≥2).
- `REFRESH_DIV`, 100000: clock cycles per digit slot (SHOW + BLANK).
- `BLANK_CYCLES`, 1000: all-anodes-off cycles at the end of each slot; 1 ≤ BLANK_CYCLES < REFRESH_DIV.
- `clk`  in  1  system clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `enable`  in  1  display on; low forces IDLE (all anodes off).
- `load`  in  1  single-cycle strobe; captures `value` and `dp_in` into the shadow register.
- `value`  in  4*DIGITS  packed nibbles; `value[3:0]` = digit 0 (rightmost).
- `dp_in`  in  DIGITS  decimal point per digit, 1 = lit.
- `lz_blank`  in  1  leading-zero suppression enable.
- `digit_data`  out  4  nibble for `sevenseg_hex.data`.
- `an_n`  out  DIGITS  anode enables, active low, at most one low.
- `dp_n`  out  1  decimal point, active low.
- `frame_tick`  out  1  one-cycle pulse at end of each full scan.

## Operation
- Registers:
  - shadow (`value`/`dp`), written on every `load`.
  - display (`value`/`dp`), used for scanning.
  - digit index `idx` (0..DIGITS-1).
  - slot counter `cnt` (0..REFRESH_DIV-1).
  - state.
- States:
  - IDLE: `an_n` all 1, `idx`=0, `cnt`=0; display ← shadow every cycle. `enable`=1 → SHOW.
  - SHOW: drive digit `idx`. `cnt` increments; when `cnt` = REFRESH_DIV-BLANK_CYCLES-1 → BLANK.
  - BLANK: `an_n` all 1; `digit_data`/`dp_n` hold. When `cnt` = REFRESH_DIV-1: `cnt`←0, `idx`←`idx`+1 (wraps DIGITS-1→0), → SHOW.
- `enable`=0 in any state → IDLE on the next edge. `an_n` all 1 from that edge; `idx`/`cnt` cleared.
- Frame boundary: the last BLANK cycle of `idx`=DIGITS-1. In that cycle `frame_tick`=1, and display ← shadow at the closing edge.
- `load` coinciding with the frame-boundary cycle: display takes the new `value`/`dp_in` directly (bypass), and shadow is also written.
- Leading-zero suppression: digit i is blanked when `lz_blank`=1 and display nibbles DIGITS-1..i are all zero.
  - Digit 0 is never blanked.
  - A blanked digit keeps `an_n` all 1 for its SHOW window; `digit_data` is still driven; timing is unchanged.
  - A set dp on a blanked digit is not shown (`dp_n`=1).
- `dp_n` = ~display dp[`idx`] during SHOW.

## Timing
- All outputs are registered. Reset values: `an_n` all 1, `digit_data`=0, `dp_n`=1, `frame_tick`=0, state IDLE, `idx`=0, `cnt`=0, shadow and display registers 0.
- IDLE→SHOW: `an_n[0]`=0 appears at the edge after `enable` is sampled high. The first SHOW cycle shows display value digit 0.
- Slot = REFRESH_DIV cycles: SHOW lasts REFRESH_DIV-BLANK_CYCLES cycles, BLANK lasts BLANK_CYCLES cycles.
- Frame = DIGITS*REFRESH_DIV cycles; `frame_tick` period = frame length.
- `load`→visible: from the first SHOW cycle of the next frame (≤ one frame + 1 cycle).
- `rst_n` assertion mid-scan: all outputs take reset values immediately (asynchronous). Release is synchronous to `clk`; scanning restarts from digit 0.

## Test plan
Parameters for all scenarios: DIGITS=4, REFRESH_DIV=8, BLANK_CYCLES=2.
- Reset, `enable`=1, `load` `value`=16'h1A3F, `dp_in`=4'b0100 → after sync to frame:
  - `an_n` sequence 1110, 1101, 1011, 0111, each low 6 cycles, then 1111 for 2 cycles.
  - `digit_data` = F, 3, A, 1.
  - `dp_n`=0 only while `an_n`=1011.
- Free run → `frame_tick` pulses exactly every 32 cycles, coincident with the last BLANK cycle of digit 3.
- `lz_blank`=1, `value`=16'h0005 → only digit 0 is lit; digits 1-3 keep `an_n`=1111. With `value`=0, digit 0 still shows 0.
- `load` 16'h1111 mid-frame, then 16'h2222 in the frame-boundary cycle:
  - the current frame finishes showing the old value;
  - the next frame shows 2 on every digit;
  - 1111 is never displayed.
- `enable` dropped during SHOW of digit 2 → `an_n`=1111 at the next edge. Re-enable → restart at digit 0 with `cnt`=0.
- `rst_n` pulsed low mid-BLANK → immediate reset values. After release, the scan restarts at digit 0 with display=0.
